// File: rtl/mc_sync_fifo.sv
// Multi-channel synchronous FIFO: NCH independent queues share one memory
// addressed {channel, pointer}, with per-channel flags, flush and sticky errors.
module mc_sync_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 5,
    parameter int NCH       = 4,
    parameter int PFULL_TH  = 8,
    parameter int PEMPTY_TH = 8,
    localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [NCH-1:0]           i_flush,
    input  logic                     i_wr_en,
    input  logic [CHW-1:0]           i_wr_ch,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic [NCH-1:0]           o_wr_full,
    output logic [NCH-1:0]           o_wr_afull,
    output logic [NCH-1:0]           o_wr_pfull,
    input  logic                     i_rd_en,
    input  logic [CHW-1:0]           i_rd_ch,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_rd_valid,
    output logic [NCH-1:0]           o_rd_empty,
    output logic [NCH-1:0]           o_rd_aempty,
    output logic [NCH-1:0]           o_rd_pempty,
    output logic [NCH*(DEPTH+1)-1:0] o_count,
    output logic [NCH-1:0]           o_ovf,
    output logic [NCH-1:0]           o_udf
);
    localparam int ENTRIES = 1 << DEPTH;
    localparam int AW      = CHW + DEPTH;
    localparam logic [DEPTH:0] FULL_CNT  = (DEPTH+1)'(ENTRIES);
    localparam logic [DEPTH:0] AFULL_CNT = (DEPTH+1)'(ENTRIES - 1);
    localparam logic [DEPTH:0] PFULL_V   = (DEPTH+1)'(PFULL_TH);
    localparam logic [DEPTH:0] PEMPTY_V  = (DEPTH+1)'(PEMPTY_TH);
    localparam logic [DEPTH:0] ONE_CNT   = (DEPTH+1)'(1);

    generate
        if (NCH < 1 || PFULL_TH < 0 || PEMPTY_TH < 0 ||
            PFULL_TH >= ENTRIES || PEMPTY_TH >= ENTRIES) begin : g_bad_params
            $error("mc_sync_fifo: illegal NCH / PFULL_TH / PEMPTY_TH");
        end
    endgenerate

    logic [WIDTH-1:0] mem [0:NCH*ENTRIES-1];
    logic [DEPTH-1:0] wr_ptr_reg [NCH];
    logic [DEPTH-1:0] rd_ptr_reg [NCH];
    logic [DEPTH:0]   count_reg  [NCH];
    logic [NCH-1:0]   ovf_reg;
    logic [NCH-1:0]   udf_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             rd_valid_reg;

    logic [NCH-1:0] wr_ok, rd_ok, wr_ovf, rd_udf;
    logic           wr_any, rd_any;
    logic [AW-1:0]  wr_addr, rd_addr;

    // An out-of-range channel index matches no gi, so it is silently ignored.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic wr_hit, rd_hit, is_full, is_empty;
        assign wr_hit   = i_wr_en && (i_wr_ch == CHW'(gi)) && !i_flush[gi];
        assign rd_hit   = i_rd_en && (i_rd_ch == CHW'(gi)) && !i_flush[gi];
        assign is_full  = (count_reg[gi] == FULL_CNT);
        assign is_empty = (count_reg[gi] == '0);
        assign wr_ok[gi]  = wr_hit && !is_full;
        assign wr_ovf[gi] = wr_hit && is_full;
        assign rd_ok[gi]  = rd_hit && !is_empty;
        assign rd_udf[gi] = rd_hit && is_empty;

        assign o_wr_full[gi]   = is_full;
        assign o_wr_afull[gi]  = (count_reg[gi] >= AFULL_CNT);
        assign o_wr_pfull[gi]  = ((FULL_CNT - count_reg[gi]) <= PFULL_V);
        assign o_rd_empty[gi]  = is_empty;
        assign o_rd_aempty[gi] = (count_reg[gi] <= ONE_CNT);
        assign o_rd_pempty[gi] = (count_reg[gi] <= PEMPTY_V);
        assign o_count[gi*(DEPTH+1) +: DEPTH+1] = count_reg[gi];
    end

    assign wr_any  = |wr_ok;
    assign rd_any  = |rd_ok;
    assign wr_addr = {i_wr_ch, wr_ptr_reg[i_wr_ch]};
    assign rd_addr = {i_rd_ch, rd_ptr_reg[i_rd_ch]};

    always_ff @(posedge i_clk) begin
        if (wr_any)
            mem[wr_addr] <= i_wr_data;
    end

    // Read and write never hit the same word in one cycle: a read needs
    // count>0 and a write needs count<ENTRIES, so the pointers differ.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_any;
            if (rd_any)
                rd_data_reg <= mem[rd_addr];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int c = 0; c < NCH; c++) begin
                wr_ptr_reg[c] <= '0;
                rd_ptr_reg[c] <= '0;
                count_reg[c]  <= '0;
            end
            ovf_reg <= '0;
            udf_reg <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (i_flush[c]) begin
                    wr_ptr_reg[c] <= '0;
                    rd_ptr_reg[c] <= '0;
                    count_reg[c]  <= '0;
                    ovf_reg[c]    <= 1'b0;
                    udf_reg[c]    <= 1'b0;
                end else begin
                    if (wr_ok[c])
                        wr_ptr_reg[c] <= wr_ptr_reg[c] + 1'b1;
                    if (rd_ok[c])
                        rd_ptr_reg[c] <= rd_ptr_reg[c] + 1'b1;
                    case ({wr_ok[c], rd_ok[c]})
                        2'b10:   count_reg[c] <= count_reg[c] + 1'b1;
                        2'b01:   count_reg[c] <= count_reg[c] - 1'b1;
                        default: count_reg[c] <= count_reg[c];
                    endcase
                    if (wr_ovf[c])
                        ovf_reg[c] <= 1'b1;
                    if (rd_udf[c])
                        udf_reg[c] <= 1'b1;
                end
            end
        end
    end

    assign o_rd_data  = rd_data_reg;
    assign o_rd_valid = rd_valid_reg;
    assign o_ovf      = ovf_reg;
    assign o_udf      = udf_reg;
endmodule

// File: tb/tb_mc_sync_fifo.sv
// Bench for mc_sync_fifo: queue-based reference model compared every cycle,
// plus directed vectors with literal expected values.
module tb_mc_sync_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 5;
    localparam int NCH   = 4;
    localparam int CHW   = 2;
    localparam int CAP   = 32;

    logic                     i_clk = 1'b0;
    logic                     i_rstn;
    logic [NCH-1:0]           i_flush;
    logic                     i_wr_en;
    logic [CHW-1:0]           i_wr_ch;
    logic [WIDTH-1:0]         i_wr_data;
    logic [NCH-1:0]           o_wr_full, o_wr_afull, o_wr_pfull;
    logic                     i_rd_en;
    logic [CHW-1:0]           i_rd_ch;
    logic [WIDTH-1:0]         o_rd_data;
    logic                     o_rd_valid;
    logic [NCH-1:0]           o_rd_empty, o_rd_aempty, o_rd_pempty;
    logic [NCH*(DEPTH+1)-1:0] o_count;
    logic [NCH-1:0]           o_ovf, o_udf;

    mc_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH),
                   .PFULL_TH(8), .PEMPTY_TH(8)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush),
        .i_wr_en(i_wr_en), .i_wr_ch(i_wr_ch), .i_wr_data(i_wr_data),
        .o_wr_full(o_wr_full), .o_wr_afull(o_wr_afull), .o_wr_pfull(o_wr_pfull),
        .i_rd_en(i_rd_en), .i_rd_ch(i_rd_ch), .o_rd_data(o_rd_data),
        .o_rd_valid(o_rd_valid), .o_rd_empty(o_rd_empty), .o_rd_aempty(o_rd_aempty),
        .o_rd_pempty(o_rd_pempty), .o_count(o_count), .o_ovf(o_ovf), .o_udf(o_udf)
    );

    always #5 i_clk = ~i_clk;

    int nvec = 0;
    int nmis = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel plus sticky error bits.
    logic [WIDTH-1:0] mq [NCH][$];
    logic [NCH-1:0]   m_ovf, m_udf;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;

    always @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_ovf = '0; m_udf = '0; m_valid = 1'b0; m_data = '0;
        end else begin
            int pre_sz [NCH];
            for (int c = 0; c < NCH; c++) pre_sz[c] = mq[c].size();
            m_valid = 1'b0;
            if (i_rd_en && !i_flush[i_rd_ch]) begin
                if (pre_sz[i_rd_ch] == 0) m_udf[i_rd_ch] = 1'b1;
                else begin
                    m_data  = mq[i_rd_ch].pop_front();
                    m_valid = 1'b1;
                end
            end
            if (i_wr_en && !i_flush[i_wr_ch]) begin
                if (pre_sz[i_wr_ch] == CAP) m_ovf[i_wr_ch] = 1'b1;
                else mq[i_wr_ch].push_back(i_wr_data);
            end
            for (int c = 0; c < NCH; c++)
                if (i_flush[c]) begin
                    mq[c].delete();
                    m_ovf[c] = 1'b0;
                    m_udf[c] = 1'b0;
                end
        end
    end

    always @(negedge i_clk) begin
        if (chk_on) begin
            logic [NCH*(DEPTH+1)-1:0] e_cnt;
            logic [NCH-1:0] e_full, e_afull, e_pfull, e_empty, e_aempty, e_pempty;
            for (int c = 0; c < NCH; c++) begin
                int sz;
                sz = mq[c].size();
                e_cnt[c*(DEPTH+1) +: DEPTH+1] = (DEPTH+1)'(sz);
                e_full[c]   = (sz == CAP);
                e_afull[c]  = (sz >= CAP - 1);
                e_pfull[c]  = ((CAP - sz) <= 8);
                e_empty[c]  = (sz == 0);
                e_aempty[c] = (sz <= 1);
                e_pempty[c] = (sz <= 8);
            end
            chk("count",    64'(o_count),     64'(e_cnt));
            chk("wr_full",  64'(o_wr_full),   64'(e_full));
            chk("wr_afull", 64'(o_wr_afull),  64'(e_afull));
            chk("wr_pfull", 64'(o_wr_pfull),  64'(e_pfull));
            chk("rd_empty", 64'(o_rd_empty),  64'(e_empty));
            chk("rd_aempty",64'(o_rd_aempty), 64'(e_aempty));
            chk("rd_pempty",64'(o_rd_pempty), 64'(e_pempty));
            chk("ovf",      64'(o_ovf),       64'(m_ovf));
            chk("udf",      64'(o_udf),       64'(m_udf));
            chk("rd_valid", 64'(o_rd_valid),  64'(m_valid));
            chk("rd_data",  64'(o_rd_data),   64'(m_data));
        end
    end

    function automatic logic [DEPTH:0] cnt(input int c);
        return o_count[c*(DEPTH+1) +: DEPTH+1];
    endfunction

    task automatic cyc();
        @(posedge i_clk);
        #2;
    endtask

    task automatic idle();
        i_wr_en = 1'b0; i_rd_en = 1'b0; i_flush = '0;
    endtask

    task automatic wr(input int ch, input logic [WIDTH-1:0] d);
        i_wr_en = 1'b1; i_wr_ch = CHW'(ch); i_wr_data = d;
        i_rd_en = 1'b0;
        cyc();
    endtask

    task automatic rd(input int ch);
        i_rd_en = 1'b1; i_rd_ch = CHW'(ch);
        i_wr_en = 1'b0;
        cyc();
    endtask

    initial begin
        i_rstn = 1'b0; i_wr_ch = '0; i_rd_ch = '0; i_wr_data = '0;
        idle();
        repeat (3) cyc();
        i_rstn = 1'b1;
        chk_on = 1'b1;
        cyc();
        chk("rst_count",  64'(o_count),    64'h0);
        chk("rst_empty",  64'(o_rd_empty), 64'hF);
        chk("rst_pempty", 64'(o_rd_pempty),64'hF);
        chk("rst_full",   64'(o_wr_full),  64'h0);
        chk("rst_valid",  64'(o_rd_valid), 64'h0);

        // Fill ch2 through all its threshold crossings.
        for (int i = 0; i < 32; i++) begin
            wr(2, 32'hA000_0000 + i);
            if (i == 22) chk("pfull_23", 64'(o_wr_pfull[2]), 64'h0);
            if (i == 23) chk("pfull_24", 64'(o_wr_pfull[2]), 64'h1);
            if (i == 29) chk("afull_30", 64'(o_wr_afull[2]), 64'h0);
            if (i == 30) chk("afull_31", 64'(o_wr_afull[2]), 64'h1);
            if (i == 30) chk("full_31",  64'(o_wr_full[2]),  64'h0);
        end
        chk("full_32",  64'(o_wr_full[2]), 64'h1);
        chk("cnt2_32",  64'(cnt(2)), 64'd32);
        chk("cnt_other",64'({cnt(3), cnt(1), cnt(0)}), 64'h0);
        wr(2, 32'hDEAD_BEEF);
        chk("ovf2",     64'(o_ovf[2]), 64'h1);
        chk("cnt2_ovf", 64'(cnt(2)), 64'd32);

        // Interleaved channels, then drain ch1 in order.
        for (int i = 0; i < 10; i++) begin
            wr(0, 32'hB000_0000 + i);
            wr(1, 32'hC000_0000 + i);
        end
        for (int i = 0; i < 10; i++) begin
            rd(1);
            chk("ch1_valid", 64'(o_rd_valid), 64'h1);
            chk("ch1_data",  64'(o_rd_data),  64'(32'hC000_0000 + i));
        end
        idle(); cyc();
        chk("ch1_novalid", 64'(o_rd_valid), 64'h0);
        chk("ch0_cnt10",   64'(cnt(0)), 64'd10);

        // Bring ch0 to 5 words, then stream through it at constant occupancy.
        for (int i = 0; i < 5; i++) rd(0);
        chk("ch0_cnt5", 64'(cnt(0)), 64'd5);
        for (int k = 0; k < 8; k++) begin
            i_wr_en = 1'b1; i_wr_ch = 2'd0; i_wr_data = 32'hD000_0000 + k;
            i_rd_en = 1'b1; i_rd_ch = 2'd0;
            cyc();
            chk("rw_cnt",  64'(cnt(0)), 64'd5);
            chk("rw_data", 64'(o_rd_data),
                64'(k < 5 ? 32'hB000_0005 + k : 32'hD000_0000 + (k - 5)));
        end
        idle(); rd(3);
        chk("udf3",       64'(o_udf[3]),   64'h1);
        chk("udf3_valid", 64'(o_rd_valid), 64'h0);

        // Flush beats a simultaneous write on the full channel.
        idle();
        i_flush = 4'b0100; i_wr_en = 1'b1; i_wr_ch = 2'd2; i_wr_data = 32'h1234_5678;
        cyc();
        chk("fl_cnt2",  64'(cnt(2)), 64'd0);
        chk("fl_empty", 64'(o_rd_empty[2]), 64'h1);
        chk("fl_ovf2",  64'(o_ovf[2]), 64'h0);
        chk("fl_udf3",  64'(o_udf[3]), 64'h1);
        idle();

        // Write+read on an empty channel: write lands, read underflows.
        i_wr_en = 1'b1; i_wr_ch = 2'd2; i_wr_data = 32'hE000_0000;
        i_rd_en = 1'b1; i_rd_ch = 2'd2;
        cyc();
        chk("we_cnt2",  64'(cnt(2)), 64'd1);
        chk("we_udf2",  64'(o_udf[2]), 64'h1);
        chk("we_valid", 64'(o_rd_valid), 64'h0);
        for (int i = 1; i < 32; i++) wr(2, 32'hE000_0000 + i);
        // Write+read on a full channel: read lands, write overflows.
        i_wr_en = 1'b1; i_wr_ch = 2'd2; i_wr_data = 32'hFFFF_0000;
        i_rd_en = 1'b1; i_rd_ch = 2'd2;
        cyc();
        chk("fr_cnt2", 64'(cnt(2)), 64'd31);
        chk("fr_ovf2", 64'(o_ovf[2]), 64'h1);
        chk("fr_data", 64'(o_rd_data), 64'hE000_0000);
        idle();

        // Reset mid-operation discards queued words.
        for (int i = 0; i < 10; i++) wr(1, 32'h5000_0000 + i);
        idle();
        chk("pre_rst_cnt1", 64'(cnt(1)), 64'd10);
        i_rstn = 1'b0;
        #1;
        chk("async_cnt", 64'(o_count), 64'h0);
        chk("async_ovf", 64'(o_ovf), 64'h0);
        cyc(); cyc();
        i_rstn = 1'b1;
        cyc();
        chk("post_rst_cnt1", 64'(cnt(1)), 64'd0);
        rd(1);
        chk("post_rst_udf1",   64'(o_udf[1]),   64'h1);
        chk("post_rst_valid",  64'(o_rd_valid), 64'h0);
        idle(); cyc(); cyc();

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/mc_sync_fifo.md
MC_SYNC_FIFO -- requirements
Module: mc_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 5, log2 of entries per channel (32 entries).
REQ-003 SHALL have parameter NCH, default 4, number of independent channels; CHW = max(1, clog2(NCH)).
REQ-004 SHALL have parameter PFULL_TH, default 8, programmable-full remaining-space threshold.
REQ-005 SHALL have parameter PEMPTY_TH, default 8, programmable-empty occupancy threshold.
REQ-006 SHALL have one clock and an asynchronous active-low reset: i_clk  in  1  sole clock, all logic on rising edge; i_rstn  in  1  async active-low reset.
REQ-007 i_flush  in  NCH  per-channel synchronous flush.
REQ-008 i_wr_en  in  1  write request; i_wr_ch  in  CHW  write channel; i_wr_data  in  WIDTH  write data.
REQ-009 o_wr_full, o_wr_afull, o_wr_pfull  out  NCH each  per-channel full, almost-full, programmable-full.
REQ-010 i_rd_en  in  1  read request; i_rd_ch  in  CHW  read channel.
REQ-011 o_rd_data  out  WIDTH  read data; o_rd_valid  out  1  read data valid pulse.
REQ-012 o_rd_empty, o_rd_aempty, o_rd_pempty  out  NCH each  per-channel empty, almost-empty, programmable-empty.
REQ-013 o_count  out  NCH*(DEPTH+1)  packed per-channel occupancy, channel c at bits [c*(DEPTH+1) +: DEPTH+1].
REQ-014 o_ovf, o_udf  out  NCH each  sticky overflow / underflow per channel.

Function
REQ-015 Storage SHALL be one memory of NCH*2^DEPTH words addressed {channel, pointer}; memory contents not reset.
REQ-016 Each channel SHALL keep wr pointer, rd pointer (DEPTH bits, natural wrap 31->0) and count (DEPTH+1 bits, 0..2^DEPTH).
REQ-017 Write accepted iff i_wr_en=1, count[i_wr_ch] < 2^DEPTH, i_flush[i_wr_ch]=0; word stored at edge, wr pointer +1.
REQ-018 Write with channel full (pre-edge count) SHALL be dropped and set o_ovf[ch] at the edge.
REQ-019 Read accepted iff i_rd_en=1, count[i_rd_ch] > 0, i_flush[i_rd_ch]=0; rd pointer +1.
REQ-020 Accepted read SHALL drive o_rd_data and o_rd_valid=1 exactly one cycle after the accepting edge; otherwise o_rd_valid=0 and o_rd_data holds last value.
REQ-021 Read with channel empty (pre-edge count) SHALL be dropped, set o_udf[ch], o_rd_valid stays 0.
REQ-022 Full/empty decisions use pre-edge count: write+read same channel when empty -> write accepted, read underflows; when full -> read accepted, write overflows; otherwise both accepted, count unchanged.
REQ-023 Write and read on different channels SHALL be fully independent in the same cycle.
REQ-024 Flush of channel c SHALL zero its pointers and count and clear o_ovf[c]/o_udf[c] at the edge; flush beats write/read on c (dropped, no ovf/udf set).
REQ-025 Flags SHALL be combinational from registered count: full = count==2^DEPTH; afull = count>=2^DEPTH-1; pfull = (2^DEPTH-count)<=PFULL_TH; empty = count==0; aempty = count<=1; pempty = count<=PEMPTY_TH.
REQ-026 Out-of-range channel index (>=NCH) SHALL be ignored with no flag change.
REQ-027 PFULL_TH and PEMPTY_TH SHALL be < 2^DEPTH; NCH >= 1; violation fails elaboration.

Reset
REQ-028 On i_rstn=0, immediately: all pointers/counts 0, o_rd_valid=0, o_rd_data=0, o_ovf=0, o_udf=0; hence o_rd_empty, o_rd_aempty, o_rd_pempty all 1, o_wr_full, o_wr_afull 0, o_wr_pfull 0 (defaults).
REQ-029 Reset asserted mid-operation SHALL discard all queued data in every channel; first read after release underflows.

Verification
REQ-030 Reset: after release, o_count=0, o_rd_empty=4'hF, o_rd_pempty=4'hF, o_wr_full=0, o_rd_valid=0.
REQ-031 Fill ch2 with A000_0000+i, i=0..31: o_wr_pfull[2]=1 after 24th write, afull after 31st, full after 32nd, count[2]=32, others 0; 33rd write DEAD_BEEF dropped, o_ovf[2]=1.
REQ-032 Alternate writes ch0=B000_0000+i, ch1=C000_0000+i (i=0..9), then read ch1 x10: C000_0000..C000_0009 in order, each one cycle after request, ch0 count stays 10.
REQ-033 Simultaneous write/read on ch0 with count 5 for 8 cycles: count stays 5, data FIFO order; read ch3 while empty: o_udf[3]=1, o_rd_valid=0.
REQ-034 Full ch2, assert i_flush[2] with write to ch2 same cycle: next cycle count[2]=0, o_rd_empty[2]=1, o_ovf[2]=0, write dropped.
REQ-035 Reset asserted with 10 words in ch1: after release count[1]=0, read ch1 sets o_udf[1]=1.
